alu_flags: RTL

Parametrised, registered successor to the CPU's 8-bit add/subtract ALU. It adds:
- WIDTH generalisation and a 4-bit operation select.
- A status-flag register (C, Z, N, V) with carry-chained ADC/SBC.
- A one-cycle result-valid strobe.

It sits between the A/B registers and the bus/flags logic. The control sequencer issues one operation per enabled cycle.

---
 rtl/alu_flags.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_flags.sv
// Registered add/subtract/logic/shift ALU with a C/Z/N/V status register and a
// one-cycle result-valid strobe. Operands and op are sampled on an enabled rising edge.
module alu_flags #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [3:0]       i_op,
  input  logic             i_flags_we,
  input  logic [WIDTH-1:0] i_reg_a,
  input  logic [WIDTH-1:0] i_reg_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_valid,
  output logic             o_flag_c,
  output logic             o_flag_z,
  output logic             o_flag_n,
  output logic             o_flag_v
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic             carry_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             wr_res;
  logic             wr_c;
  logic             wr_v;
  logic             wr_zn;
  logic             flags_en;

  // Subtraction is A + ~B + cin; SUB/CMP force cin=1, ADC/SBC chain the registered carry.
  always_comb begin
    is_sub   = (i_op == OP_SUB) || (i_op == OP_SBC) || (i_op == OP_CMP);
    b_eff    = is_sub ? ~i_reg_b : i_reg_b;
    carry_in = 1'b0;
    if ((i_op == OP_ADC) || (i_op == OP_SBC)) begin
      carry_in = o_flag_c;
    end else if ((i_op == OP_SUB) || (i_op == OP_CMP)) begin
      carry_in = 1'b1;
    end
    sum = {1'b0, i_reg_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
  end

  always_comb begin
    alu_res = o_result;
    alu_c   = o_flag_c;
    alu_v   = o_flag_v;
    wr_res  = 1'b0;
    wr_c    = 1'b0;
    wr_v    = 1'b0;
    wr_zn   = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        // Overflow of A + b_eff: same operand signs, different result sign.
        alu_v   = (i_reg_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum[WIDTH-1] != i_reg_a[WIDTH-1]);
        wr_res  = (i_op != OP_CMP);
        wr_c    = 1'b1;
        wr_v    = 1'b1;
        wr_zn   = 1'b1;
      end
      OP_AND: begin
        alu_res = i_reg_a & i_reg_b;
        wr_res  = 1'b1;
        wr_zn   = 1'b1;
      end
      OP_OR: begin
        alu_res = i_reg_a | i_reg_b;
        wr_res  = 1'b1;
        wr_zn   = 1'b1;
      end
      OP_XOR: begin
        alu_res = i_reg_a ^ i_reg_b;
        wr_res  = 1'b1;
        wr_zn   = 1'b1;
      end
      OP_SHL: begin
        alu_res = {i_reg_a[WIDTH-2:0], 1'b0};
        alu_c   = i_reg_a[WIDTH-1];
        wr_res  = 1'b1;
        wr_c    = 1'b1;
        wr_zn   = 1'b1;
      end
      OP_SHR: begin
        alu_res = {1'b0, i_reg_a[WIDTH-1:1]};
        alu_c   = i_reg_a[0];
        wr_res  = 1'b1;
        wr_c    = 1'b1;
        wr_zn   = 1'b1;
      end
      default: begin
      end
    endcase
    flags_en = i_enable && (i_flags_we || (i_op == OP_CMP));
  end

  // o_valid is a strobe, not a handshake: high for the cycle after every enabled
  // edge (NOPs included), telling the consumer o_result and the flags are current.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_result <= '0;
      o_valid  <= 1'b0;
      o_flag_c <= 1'b0;
      o_flag_z <= 1'b0;
      o_flag_n <= 1'b0;
      o_flag_v <= 1'b0;
    end else begin
      o_valid <= i_enable;
      if (i_enable && wr_res) begin
        o_result <= alu_res;
      end
      if (flags_en) begin
        if (wr_c) begin
          o_flag_c <= alu_c;
        end
        if (wr_v) begin
          o_flag_v <= alu_v;
        end
        if (wr_zn) begin
          o_flag_z <= (alu_res == '0);
          o_flag_n <= alu_res[WIDTH-1];
        end
      end
    end
  end

endmodule
